crypto_req_sequencer: RTL and testbench
=======================================

CRYPTO_REQ_SEQUENCER -- requirements
Module: crypto_req_sequencer

Interface
REQ-001 SHALL have parameter BGN_CYCLES, default 10: number of cycles bgn is held high per operation (legal 1..255).
REQ-002 SHALL have parameter TIMEOUT, default 200: maximum number of cycles spent waiting for crypto_done before error (legal 1..1023).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  processor request valid.
REQ-006 req_ready  output  1  request FIFO can accept.
REQ-007 req_mode  input  2  01 = encrypt, 10 = decrypt, 00/11 = illegal.
REQ-008 req_key  input  16  key word.
REQ-009 req_data  input  16  data word.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  consumer accepts result.
REQ-012 rsp_data  output  16  result data.
REQ-013 rsp_key  output  16  result (round) key.
REQ-014 rsp_err  output  1  1 = illegal mode or timeout.
REQ-015 key_inbus  output  16  key to crypto core.
REQ-016 data_inbus  output  16  data to crypto core.
REQ-017 cript_or_decript_signal  output  2  mode to crypto core.
REQ-018 bgn  output  1  start strobe to crypto core.
REQ-019 crypto_done  input  1  registered completion pulse from the core (its registered c21).
REQ-020 crypto_data_out  input  16  core data_outbus.
REQ-021 crypto_key_out  input  16  core key_outbus.
REQ-022 busy  output  1  FSM is not in IDLE.

Function
REQ-023 SHALL buffer requests in a 2-entry FIFO (mode, key, data); a request is accepted when req_valid && req_ready; req_ready = !full.
REQ-024 Simultaneous FIFO push and pop when full SHALL NOT be allowed (req_ready already low); simultaneous push and pop at count 1 SHALL leave count at 1.
REQ-025 FSM states SHALL be IDLE, START, WAIT, CAPTURE, RESP.
REQ-026 IDLE: if FIFO non-empty, pop the head into the operation register; legal mode -> START; illegal mode -> RESP with rsp_err=1 and rsp_data=rsp_key=0, and bgn is never raised.
REQ-027 key_inbus, data_inbus and cript_or_decript_signal SHALL be driven from the operation register and held stable from START entry until the next pop.
REQ-028 START: bgn=1 for exactly BGN_CYCLES cycles, counted by a down-counter, then bgn=0 -> WAIT.
REQ-029 WAIT: a timeout counter cleared on WAIT entry increments every cycle; when crypto_done=1 -> CAPTURE; when the counter reaches TIMEOUT without done -> RESP with rsp_err=1, rsp_data=rsp_key=0.
REQ-030 A crypto_done seen during START SHALL be ignored.
REQ-031 CAPTURE (one cycle): latch crypto_data_out into rsp_data and crypto_key_out into rsp_key, set rsp_err=0 -> RESP; the capture point is one cycle after done because the core updates key_outbus on the same edge as done.
REQ-032 RESP: rsp_valid=1; rsp_data, rsp_key and rsp_err stable while rsp_valid && !rsp_ready; when rsp_ready=1 -> IDLE, with rsp_valid low the next cycle.
REQ-033 Latency SHALL be: legal request into an empty FIFO with idle FSM, done arriving after N WAIT cycles -> rsp_valid asserted 1 (pop) + BGN_CYCLES + N + 1 (capture) cycles after acceptance.
REQ-034 The FIFO SHALL continue accepting requests in all states.
REQ-035 busy = (state != IDLE).

Reset
REQ-036 When rst=0, asynchronously: state=IDLE, FIFO empty, both counters 0, bgn=0, key_inbus=data_inbus=0, cript_or_decript_signal=00, rsp_valid=0, rsp_data=rsp_key=0, rsp_err=0, busy=0, req_ready=1.
REQ-037 Reset mid-operation SHALL abort the operation and discard queued requests; no response is produced for them.

Verification
REQ-038 Encrypt: mode 01, key 1325, data 59B3; core model pulses done 30 cycles after bgn falls with data A5A5 / key 3C3C -> bgn high 10 cycles, one rsp with data A5A5, key 3C3C, err 0.
REQ-039 Illegal: mode 11 -> bgn stays 0, rsp_valid one cycle after pop, err 1, data/key 0000.
REQ-040 Timeout: mode 10, key A058, data 47E9, no done -> rsp_err=1 after 200 WAIT cycles; FSM returns to IDLE after rsp_ready.
REQ-041 Backpressure: 3 back-to-back requests while busy -> req_ready low after 2 are queued; rsp_ready held low 5 cycles -> rsp fields stable; all 3 responses returned in order.
REQ-042 Reset asserted during WAIT with 1 queued -> all outputs take reset values immediately; no response after release.
REQ-043 done pulse injected during START -> ignored; result is captured only from the later done.

Source files
------------

// File: rtl/crypto_req_sequencer.sv
// Request sequencer for a 16-bit crypto core: 2-deep request FIFO,
// bgn strobe generation, done/timeout wait, and a held response.
module crypto_req_sequencer #(
  parameter int BGN_CYCLES = 10,
  parameter int TIMEOUT    = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_mode,
  input  logic [15:0] req_key,
  input  logic [15:0] req_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [15:0] rsp_key,
  output logic        rsp_err,
  output logic [15:0] key_inbus,
  output logic [15:0] data_inbus,
  output logic [1:0]  cript_or_decript_signal,
  output logic        bgn,
  input  logic        crypto_done,
  input  logic [15:0] crypto_data_out,
  input  logic [15:0] crypto_key_out,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, START, WAIT, CAPTURE, RESP
  } state_t;

  localparam logic [7:0] BGN_LOAD = 8'(BGN_CYCLES);
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [1:0]  f_mode [2];
  logic [15:0] f_key  [2];
  logic [15:0] f_data [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;
  logic        push, pop, legal;
  logic        ld_err, ld_cap;
  logic [7:0]  bgn_cnt;
  logic [9:0]  tmo_cnt;

  assign req_ready = (count != 2'd2);
  assign push      = req_valid && req_ready;
  assign legal     = ^f_mode[rd_ptr];
  assign busy      = (state != IDLE);
  assign bgn       = (state == START);
  assign rsp_valid = (state == RESP);

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    ld_err  = 1'b0;
    ld_cap  = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != 2'd0) begin
          pop     = 1'b1;
          ld_err  = !legal;
          state_n = legal ? START : RESP;
        end
      end
      START: begin
        if (bgn_cnt == 8'd1) state_n = WAIT;
      end
      WAIT: begin
        if (crypto_done) begin
          state_n = CAPTURE;
        end else if (tmo_cnt == TMO_LAST) begin
          ld_err  = 1'b1;
          state_n = RESP;
        end
      end
      CAPTURE: begin
        ld_cap  = 1'b1;
        state_n = RESP;
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        f_mode[i] <= 2'b00;
        f_key[i]  <= 16'h0;
        f_data[i] <= 16'h0;
      end
    end else begin
      if (push) begin
        f_mode[wr_ptr] <= req_mode;
        f_key[wr_ptr]  <= req_key;
        f_data[wr_ptr] <= req_data;
        wr_ptr         <= !wr_ptr;
      end
      if (pop) rd_ptr <= !rd_ptr;
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
    end
  end

  // Core inputs stay on the popped request until the next pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_inbus               <= 16'h0;
      data_inbus              <= 16'h0;
      cript_or_decript_signal <= 2'b00;
    end else if (pop) begin
      key_inbus               <= f_key[rd_ptr];
      data_inbus              <= f_data[rd_ptr];
      cript_or_decript_signal <= f_mode[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bgn_cnt <= 8'd0;
      tmo_cnt <= 10'd0;
    end else begin
      if (pop && legal)
        bgn_cnt <= BGN_LOAD;
      else if (state == START && bgn_cnt != 8'd0)
        bgn_cnt <= bgn_cnt - 8'd1;
      if (state == WAIT && state_n == WAIT)
        tmo_cnt <= tmo_cnt + 10'd1;
      else
        tmo_cnt <= 10'd0;
    end
  end

  // Core outputs settle on the done edge, so they are taken a cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_data <= 16'h0;
      rsp_key  <= 16'h0;
      rsp_err  <= 1'b0;
    end else if (ld_err) begin
      rsp_data <= 16'h0;
      rsp_key  <= 16'h0;
      rsp_err  <= 1'b1;
    end else if (ld_cap) begin
      rsp_data <= crypto_data_out;
      rsp_key  <= crypto_key_out;
      rsp_err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_crypto_req_sequencer.sv
// Directed bench for crypto_req_sequencer with a behavioural core
// and a response scoreboard.
module tb_crypto_req_sequencer;

  typedef struct packed {
    logic [15:0] d;
    logic [15:0] k;
    logic        e;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_mode;
  logic [15:0] req_key, req_data;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data, rsp_key;
  logic        rsp_err;
  logic [15:0] key_inbus, data_inbus;
  logic [1:0]  cript_or_decript_signal;
  logic        bgn, busy;
  logic        crypto_done;
  logic [15:0] crypto_data_out, crypto_key_out;

  crypto_req_sequencer dut (
    .clk                     (clk),
    .rst                     (rst),
    .req_valid               (req_valid),
    .req_ready               (req_ready),
    .req_mode                (req_mode),
    .req_key                 (req_key),
    .req_data                (req_data),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_data                (rsp_data),
    .rsp_key                 (rsp_key),
    .rsp_err                 (rsp_err),
    .key_inbus               (key_inbus),
    .data_inbus              (data_inbus),
    .cript_or_decript_signal (cript_or_decript_signal),
    .bgn                     (bgn),
    .crypto_done             (crypto_done),
    .crypto_data_out         (crypto_data_out),
    .crypto_key_out          (crypto_key_out),
    .busy                    (busy)
  );

  always #5 clk = ~clk;

  rsp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  bit          core_en = 1'b0;
  bit          use_fixed = 1'b0;
  bit          glitch = 1'b0;
  int          done_dly = 30;
  logic [15:0] fix_d = 16'h0;
  logic [15:0] fix_k = 16'h0;

  localparam logic [79:0] RST_EXP = 80'h1 << 70;

  task automatic chk(input string tag, input logic [79:0] obs,
                     input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] out_vec();
    return {9'b0, req_ready, rsp_valid, rsp_err, bgn, busy,
            cript_or_decript_signal, key_inbus, data_inbus,
            rsp_data, rsp_key};
  endfunction

  function automatic rsp_t core_rsp(input logic [15:0] k,
                                    input logic [15:0] d);
    return {d ^ k, ~k, 1'b0};
  endfunction

  // Core model: optional spurious done during bgn, real done after bgn falls.
  initial begin
    crypto_done     = 1'b0;
    crypto_data_out = 16'h0;
    crypto_key_out  = 16'h0;
    forever begin
      @(posedge bgn);
      if (glitch) begin
        repeat (3) @(posedge clk);
        #1;
        crypto_done     = 1'b1;
        crypto_data_out = 16'hDEAD;
        crypto_key_out  = 16'hBEEF;
        @(posedge clk);
        #1 crypto_done = 1'b0;
      end
      @(negedge bgn);
      if (core_en) begin
        repeat (done_dly) @(posedge clk);
        #1;
        crypto_done     = 1'b1;
        crypto_data_out = use_fixed ? fix_d : (data_inbus ^ key_inbus);
        crypto_key_out  = use_fixed ? fix_k : ~key_inbus;
        @(posedge clk);
        #1 crypto_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1 && rsp_valid === 1'b1) begin
      chk("rsp_expected", 80'(sb.size() != 0), 80'd1);
      if (sb.size() != 0) begin
        chk(rsp_ready ? "rsp" : "rsp_hold",
            {47'b0, rsp_data, rsp_key, rsp_err},
            {47'b0, sb[0].d, sb[0].k, sb[0].e});
        if (rsp_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic send(input logic [1:0] m, input logic [15:0] k,
                      input logic [15:0] d, input bit exp_rsp,
                      input rsp_t e);
    int   n = 0;
    logic r = 1'b0;
    if (exp_rsp) sb.push_back(e);
    req_valid = 1'b1;
    req_mode  = m;
    req_key   = k;
    req_data  = d;
    do begin
      @(negedge clk);
      r = req_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 500);
    req_valid = 1'b0;
    if (!r) chk("accept_timeout", 80'(r), 80'd1);
  endtask

  task automatic wait_rsp(output int k, output int nb);
    k  = 0;
    nb = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
      if (bgn) nb++;
    end while (!rsp_valid && k < 2000);
  endtask

  int lat, nbgn, n;

  initial begin
    rst       = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    req_mode  = 2'b00;
    req_key   = 16'h0;
    req_data  = 16'h0;
    #12;
    chk("reset_outputs", out_vec(), RST_EXP);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // Encrypt with fixed core result
    core_en   = 1'b1;
    use_fixed = 1'b1;
    fix_d     = 16'hA5A5;
    fix_k     = 16'h3C3C;
    done_dly  = 30;
    send(2'b01, 16'h1325, 16'h59B3, 1'b1, {16'hA5A5, 16'h3C3C, 1'b0});
    wait_rsp(lat, nbgn);
    chk("enc_latency", 80'(lat), 80'd43);
    chk("enc_bgn_cycles", 80'(nbgn), 80'd10);
    chk("enc_core_bus",
        {62'b0, cript_or_decript_signal, key_inbus, data_inbus},
        {62'b0, 2'b01, 16'h1325, 16'h59B3});
    repeat (2) @(posedge clk);
    #1;
    chk("enc_idle", {78'b0, busy, rsp_valid}, 80'd0);

    // Illegal mode
    send(2'b11, 16'h1111, 16'h2222, 1'b1, {16'h0, 16'h0, 1'b1});
    wait_rsp(lat, nbgn);
    chk("ill_latency", 80'(lat), 80'd1);
    chk("ill_bgn", 80'(nbgn), 80'd0);
    repeat (2) @(posedge clk);
    #1;

    // Timeout
    core_en   = 1'b0;
    use_fixed = 1'b0;
    send(2'b10, 16'hA058, 16'h47E9, 1'b1, {16'h0, 16'h0, 1'b1});
    wait_rsp(lat, nbgn);
    chk("tmo_latency", 80'(lat), 80'd211);
    chk("tmo_bgn_cycles", 80'(nbgn), 80'd10);
    @(posedge clk);
    #1;
    chk("tmo_idle", {78'b0, busy, rsp_valid}, 80'd0);

    // Spurious done during START
    core_en  = 1'b1;
    glitch   = 1'b1;
    done_dly = 5;
    send(2'b01, 16'h1234, 16'h5678, 1'b1, core_rsp(16'h1234, 16'h5678));
    wait_rsp(lat, nbgn);
    chk("glitch_latency", 80'(lat), 80'd18);
    glitch = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Backpressure on both sides
    done_dly  = 4;
    rsp_ready = 1'b0;
    send(2'b01, 16'h0F0F, 16'h1111, 1'b1, core_rsp(16'h0F0F, 16'h1111));
    @(posedge clk);
    #1;
    send(2'b10, 16'h2222, 16'h3333, 1'b1, core_rsp(16'h2222, 16'h3333));
    send(2'b01, 16'h4444, 16'h5555, 1'b1, core_rsp(16'h4444, 16'h5555));
    chk("bp_full", {78'b0, req_ready, busy}, 80'd1);
    fork
      send(2'b10, 16'h6666, 16'h7777, 1'b1, core_rsp(16'h6666, 16'h7777));
      begin
        n = 0;
        while (!rsp_valid && n < 200) begin
          @(posedge clk);
          #1;
          n++;
        end
        repeat (5) @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
    join
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_drain", 80'(sb.size()), 80'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_idle", {78'b0, busy, req_ready}, 80'd1);

    // Reset during WAIT with one request queued
    core_en = 1'b0;
    send(2'b01, 16'hAAAA, 16'h5555, 1'b0, '0);
    send(2'b10, 16'hBBBB, 16'hCCCC, 1'b0, '0);
    repeat (15) @(posedge clk);
    #1;
    chk("rst_pre_wait", {77'b0, busy, bgn, req_ready}, 80'b101);
    #2 rst = 1'b0;
    #1;
    chk("rst_async", out_vec(), RST_EXP);
    @(negedge clk) rst = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    chk("rst_no_resume", {77'b0, busy, bgn, req_ready}, 80'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
